// File: rtl/counter_nbit_down_reload.sv
// counter_nbit_down_reload: N-bit down counter with one-shot or periodic auto-reload.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      load load_val, latch mode and enter RUN
//   stop       abort to IDLE (highest priority)
//   mode       0 = one-shot, 1 = periodic; sampled on start
//   load_val   terminal period value; one period is load_val+1 enabled cycles
//   count_enb  decrement enable, used in RUN only
//   count      current counter value
//   tc         one-cycle terminal-count pulse
//   busy       high in RUN
//   done       high in DONE
module counter_nbit_down_reload #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         mode,
  input  logic [N-1:0] load_val,
  input  logic         count_enb,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t       state;
  logic [N-1:0] reload_reg;
  logic         mode_reg;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      mode_reg   <= 1'b0;
      tc         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (stop) begin
        state <= IDLE;
        count <= '0;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (start) begin
        state      <= RUN;
        count      <= load_val;
        reload_reg <= load_val;
        mode_reg   <= mode;
        busy       <= 1'b1;
        done       <= 1'b0;
      end else if (state == RUN && count_enb) begin
        if (count != '0) begin
          count <= count - 1'b1;
        end else begin
          // terminal event: the period just finished at zero
          tc <= 1'b1;
          if (mode_reg) begin
            count <= reload_reg;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_counter_nbit_down_reload.sv
// tb_counter_nbit_down_reload: directed and random checks against a period-arithmetic model.
module tb_counter_nbit_down_reload;
  localparam int N = 8;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         mode = 1'b0;
  logic [N-1:0] load_val = '0;
  logic         count_enb = 1'b0;
  logic [N-1:0] count;
  logic         tc;
  logic         busy;
  logic         done;
  int           n_chk = 0;
  int           n_fail = 0;
  // model: run active, finished (one-shot), period L, periodic flag, enabled cycles since start
  bit           m_act = 0;
  bit           m_fin = 0;
  int           m_l = 0;
  bit           m_per = 0;
  longint       m_k = 0;
  bit           m_tc = 0;

  counter_nbit_down_reload #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .load_val(load_val), .count_enb(count_enb), .count(count), .tc(tc),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag);
    logic [N-1:0] e_count;
    e_count = (!m_act || m_fin) ? '0 : N'(m_l - int'(m_k % (m_l + 1)));
    n_chk++;
    assert (count === e_count) else begin
      n_fail++;
      $error("FAIL %s count: got %0d expected %0d", tag, count, e_count);
    end
    n_chk++;
    assert (tc === m_tc) else begin
      n_fail++;
      $error("FAIL %s tc: got %b expected %b", tag, tc, m_tc);
    end
    n_chk++;
    assert (busy === (m_act && !m_fin)) else begin
      n_fail++;
      $error("FAIL %s busy: got %b expected %b", tag, busy, m_act && !m_fin);
    end
    n_chk++;
    assert (done === m_fin) else begin
      n_fail++;
      $error("FAIL %s done: got %b expected %b", tag, done, m_fin);
    end
  endtask

  task automatic step(input string tag, input logic st, input logic sp, input logic md,
                      input logic [N-1:0] lv, input logic en);
    start = st; stop = sp; mode = md; load_val = lv; count_enb = en;
    @(posedge clk);
    m_tc = 0;
    if (sp) begin
      m_act = 0; m_fin = 0;
    end else if (st) begin
      m_act = 1; m_fin = 0; m_k = 0; m_l = int'(lv); m_per = md;
    end else if (m_act && !m_fin && en) begin
      m_k++;
      m_tc = (m_k % (m_l + 1)) == 0;
      if (m_tc && !m_per) m_fin = 1;
    end
    #1;
    chk(tag);
  endtask

  initial begin
    #12;
    chk("reset");
    @(negedge clk) reset = 1'b1;
    step("idle_enb", 0, 0, 0, 8'd5, 1);
    step("os_start", 1, 0, 0, 8'd3, 1);
    for (int i = 0; i < 6; i++) step("oneshot", 0, 0, 0, 8'd0, 1);
    step("per_start", 1, 0, 1, 8'd2, 1);
    for (int i = 0; i < 9; i++) step("periodic", 0, 0, 0, 8'd0, 1);
    step("gate_start", 1, 0, 0, 8'd4, 0);
    for (int i = 0; i < 12; i++) step("gating", 0, 0, 0, 8'd0, i % 2 == 0);
    step("sv_start", 1, 0, 1, 8'd1, 0);
    step("sv_dec", 0, 0, 0, 8'd0, 1);
    step("stop_vs_tc", 0, 1, 0, 8'd0, 1);
    step("stop_idle", 0, 0, 0, 8'd0, 1);
    step("rs_start", 1, 0, 0, 8'd10, 1);
    for (int i = 0; i < 3; i++) step("rs_count", 0, 0, 0, 8'd0, 1);
    step("restart", 1, 0, 0, 8'd1, 1);
    for (int i = 0; i < 4; i++) step("rs_after", 0, 0, 0, 8'd0, 1);
    step("ar_start", 1, 0, 1, 8'd5, 1);
    step("ar_run", 0, 0, 0, 8'd0, 1);
    step("ar_run", 0, 0, 0, 8'd0, 1);
    #2 reset = 1'b0;
    #1;
    m_act = 0; m_fin = 0; m_tc = 0;
    chk("async_reset");
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_held");
    start = 1'b0;
    @(negedge clk) reset = 1'b1;
    step("post_release", 0, 0, 0, 8'd0, 1);
    step("z_start", 1, 0, 1, 8'd0, 1);
    for (int i = 0; i < 5; i++) step("zero_per", 0, 0, 0, 8'd0, 1);
    step("full_start", 1, 0, 0, 8'hFF, 1);
    for (int i = 0; i < 258; i++) step("full_range", 0, 0, 0, 8'd0, 1);
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] lv;
      lv = ($urandom_range(0, 9) == 0) ? 8'(255 - $urandom_range(0, 3)) : 8'($urandom_range(0, 5));
      step("random", $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
           1'($urandom), lv, $urandom_range(0, 3) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
